// File: rtl/instr_mem_loadable.sv
// Loadable, word-addressed instruction memory for the MIPS fetch stage.
// A boot-load port streams the program in; the fetch port serves the PC with one cycle of latency.
module instr_mem_loadable #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  LoadStart,
    input  logic                  LoadValid,
    input  logic [DATA_WIDTH-1:0] LoadData,
    input  logic                  LoadDone,
    output logic                  Loading,
    output logic [DEPTH_LOG2:0]   LoadCount,
    output logic                  LoadOverflow,
    input  logic                  FetchReq,
    input  logic                  Stall,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic                  AddrFault
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                  state_r;
    state_e                  state_s;
    logic [DEPTH_LOG2:0]     count_r;
    logic [DEPTH_LOG2:0]     count_s;
    logic                    overflow_r;
    logic                    overflow_s;
    logic                    loading_r;
    logic                    wr_en_s;
    logic [DEPTH_LOG2-1:0]   wr_idx_s;

    logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0]   rd_idx_s;
    logic                    addr_fault_s;
    logic [DATA_WIDTH-1:0]   instr_r;
    logic [DATA_WIDTH-1:0]   instr_s;
    logic                    valid_r;
    logic                    valid_s;
    logic                    fault_r;
    logic                    fault_s;

    // The write pointer and the word count are the same quantity; the pointer stops at FULL_COUNT.
    assign wr_idx_s = count_r[DEPTH_LOG2-1:0];

    // Fetch address decode: word index plus misalignment / out-of-range detection.
    assign rd_idx_s     = Address[DEPTH_LOG2+1:2];
    assign addr_fault_s = (Address[1:0] != 2'b00) ||
                          ((Address >> (DEPTH_LOG2 + 2)) != {ADDR_WIDTH{1'b0}});

    // Load FSM next-state, write pointer, overflow flag and write enable.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        wr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (LoadStart) begin
                    state_s    = ST_LOAD;
                    count_s    = {(DEPTH_LOG2 + 1){1'b0}};
                    overflow_s = 1'b0;
                end else if (LoadDone) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A repeated LoadStart restarts the load; any word on that cycle is discarded.
                if (LoadStart) begin
                    state_s    = ST_LOAD;
                    count_s    = {(DEPTH_LOG2 + 1){1'b0}};
                    overflow_s = 1'b0;
                end else begin
                    if (LoadValid) begin
                        if (count_r == FULL_COUNT) begin
                            overflow_s = 1'b1;
                        end else begin
                            wr_en_s = 1'b1;
                            count_s = count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    if (LoadDone) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
            end
            ST_RUN: begin
                if (LoadStart) begin
                    state_s    = ST_LOAD;
                    count_s    = {(DEPTH_LOG2 + 1){1'b0}};
                    overflow_s = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                count_s    = {(DEPTH_LOG2 + 1){1'b0}};
                overflow_s = 1'b0;
            end
        endcase
    end

    // Load FSM state register and registered load status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= {(DEPTH_LOG2 + 1){1'b0}};
            overflow_r <= 1'b0;
            loading_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            overflow_r <= overflow_s;
            loading_r  <= (state_s == ST_LOAD);
        end
    end

    // Memory array; contents survive reset so a program can be rerun without reloading.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_idx_s] <= LoadData;
        end
    end

    // Fetch output selection, highest priority first: stall hold, not running, hit, fault, idle.
    always_comb begin
        instr_s = instr_r;
        valid_s = valid_r;
        fault_s = fault_r;
        if (Stall) begin
            instr_s = instr_r;
            valid_s = valid_r;
            fault_s = fault_r;
        end else if (state_r != ST_RUN) begin
            instr_s = NOP_WORD;
            valid_s = 1'b0;
            fault_s = 1'b0;
        end else if (FetchReq && !addr_fault_s) begin
            instr_s = mem_r[rd_idx_s];
            valid_s = 1'b1;
            fault_s = 1'b0;
        end else if (FetchReq) begin
            instr_s = NOP_WORD;
            valid_s = 1'b1;
            fault_s = 1'b1;
        end else begin
            instr_s = instr_r;
            valid_s = 1'b0;
            fault_s = 1'b0;
        end
    end

    // Fetch output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            instr_r <= instr_s;
            valid_r <= valid_s;
            fault_r <= fault_s;
        end
    end

    assign Loading      = loading_r;
    assign LoadCount    = count_r;
    assign LoadOverflow = overflow_r;
    assign Instruction  = instr_r;
    assign InstrValid   = valid_r;
    assign AddrFault    = fault_r;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: a 256-word instance and a 4-word instance.
// Expected fetch responses are queued at issue time and popped by per-instance monitors.
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_ls, a_lv, a_done, a_freq, a_stall;
    logic [31:0] a_ld, a_addr, a_instr;
    logic        a_loading, a_ovf, a_valid, a_fault;
    logic [8:0]  a_count;

    logic        b_ls, b_lv, b_done, b_freq, b_stall;
    logic [31:0] b_ld, b_addr, b_instr;
    logic        b_loading, b_ovf, b_valid, b_fault;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [31:0] prog[0:17];
    logic [31:0] reload[0:2];

    always #5 clk = ~clk;

    instr_mem_loadable #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(8), .NOP_WORD(32'h00000000)) u_dut_a (
        .clk(clk), .reset(reset),
        .LoadStart(a_ls), .LoadValid(a_lv), .LoadData(a_ld), .LoadDone(a_done),
        .Loading(a_loading), .LoadCount(a_count), .LoadOverflow(a_ovf),
        .FetchReq(a_freq), .Stall(a_stall), .Address(a_addr),
        .Instruction(a_instr), .InstrValid(a_valid), .AddrFault(a_fault)
    );

    instr_mem_loadable #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(2), .NOP_WORD(32'h00000000)) u_dut_b (
        .clk(clk), .reset(reset),
        .LoadStart(b_ls), .LoadValid(b_lv), .LoadData(b_ld), .LoadDone(b_done),
        .Loading(b_loading), .LoadCount(b_count), .LoadOverflow(b_ovf),
        .FetchReq(b_freq), .Stall(b_stall), .Address(b_addr),
        .Instruction(b_instr), .InstrValid(b_valid), .AddrFault(b_fault)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch_a(input logic [31:0] addr, input logic [32:0] exp);
        a_freq = 1'b1;
        a_addr = addr;
        exp_a.push_back(exp);
        cyc();
    endtask

    task automatic fetch_b(input logic [31:0] addr, input logic [32:0] exp);
        b_freq = 1'b1;
        b_addr = addr;
        exp_b.push_back(exp);
        cyc();
    endtask

    // Monitor for instance A: every valid response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL fetch_a_unexpected: got instr=%h fault=%b with nothing expected", a_instr, a_fault);
            end else begin
                logic [32:0] e;
                e = exp_a.pop_front();
                if ({a_fault, a_instr} !== e) begin
                    errors++;
                    $display("FAIL fetch_a: got fault=%b instr=%h expected fault=%b instr=%h",
                             a_fault, a_instr, e[32], e[31:0]);
                end
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (b_valid === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL fetch_b_unexpected: got instr=%h fault=%b with nothing expected", b_instr, b_fault);
            end else begin
                logic [32:0] e;
                e = exp_b.pop_front();
                if ({b_fault, b_instr} !== e) begin
                    errors++;
                    $display("FAIL fetch_b: got fault=%b instr=%h expected fault=%b instr=%h",
                             b_fault, b_instr, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        prog[0] = 32'h20040003;
        prog[1] = 32'h0C000003;
        for (int i = 2; i < 18; i++) prog[i] = 32'hA5000000 + 32'(i);
        for (int i = 0; i < 3; i++) reload[i] = 32'h11110000 + 32'(i);

        reset = 1'b1;
        a_ls = 1'b0; a_lv = 1'b0; a_done = 1'b0; a_freq = 1'b0; a_stall = 1'b0;
        a_ld = 32'h0; a_addr = 32'h0;
        b_ls = 1'b0; b_lv = 1'b0; b_done = 1'b0; b_freq = 1'b0; b_stall = 1'b0;
        b_ld = 32'h0; b_addr = 32'h0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state.
        chk("rst_loading", 64'(a_loading), 64'h0);
        chk("rst_count", 64'(a_count), 64'h0);
        chk("rst_ovf", 64'(a_ovf), 64'h0);
        chk("rst_instr", 64'(a_instr), 64'h0);
        chk("rst_valid", 64'(a_valid), 64'h0);
        chk("rst_fault", 64'(a_fault), 64'h0);

        // Load 18 words then run.
        a_ls = 1'b1; cyc(); a_ls = 1'b0;
        chk("load_entry_loading", 64'(a_loading), 64'h1);
        for (int i = 0; i < 18; i++) begin
            a_lv = 1'b1; a_ld = prog[i]; cyc();
        end
        a_lv = 1'b0;
        chk("load18_count", 64'(a_count), 64'd18);
        a_done = 1'b1; cyc(); a_done = 1'b0;
        chk("run_loading", 64'(a_loading), 64'h0);
        chk("run_count", 64'(a_count), 64'd18);

        fetch_a(32'h0, {1'b0, 32'h20040003});
        fetch_a(32'h4, {1'b0, 32'h0C000003});
        fetch_a(32'h44, {1'b0, 32'hA5000011});
        a_freq = 1'b0; cyc();
        chk("idle_fetch_valid", 64'(a_valid), 64'h0);
        chk("idle_fetch_hold", 64'(a_instr), 64'hA5000011);

        // Stall hold for 3 cycles while the address moves.
        fetch_a(32'h8, {1'b0, 32'hA5000002});
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_addr = 32'h10 + 32'(4 * i);
            exp_a.push_back({1'b0, 32'hA5000002});
            cyc();
        end
        a_stall = 1'b0; a_freq = 1'b0; cyc();

        // Misaligned and out-of-range fetches.
        fetch_a(32'h6, {1'b1, 32'h00000000});
        fetch_a(32'h400, {1'b1, 32'h00000000});
        a_freq = 1'b0; cyc();
        chk("fault_clear", 64'(a_fault), 64'h0);

        // Reset after 3 of 10 words; memory keeps them, count clears.
        a_ls = 1'b1; cyc(); a_ls = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_lv = 1'b1; a_ld = reload[i]; cyc();
        end
        a_lv = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("midrst_loading", 64'(a_loading), 64'h0);
        chk("midrst_count", 64'(a_count), 64'h0);
        a_freq = 1'b1; a_addr = 32'h0; cyc(); a_freq = 1'b0;
        chk("idle_no_service", 64'(a_valid), 64'h0);
        a_done = 1'b1; cyc(); a_done = 1'b0;
        chk("idle_to_run_count", 64'(a_count), 64'h0);
        fetch_a(32'h0, {1'b0, reload[0]});
        fetch_a(32'h4, {1'b0, reload[1]});
        fetch_a(32'h8, {1'b0, reload[2]});
        fetch_a(32'hC, {1'b0, 32'hA5000003});
        a_freq = 1'b0; cyc();

        // LoadValid and LoadDone together on the first word.
        a_ls = 1'b1; cyc(); a_ls = 1'b0;
        a_lv = 1'b1; a_done = 1'b1; a_ld = 32'hCAFEF00D; cyc();
        a_lv = 1'b0; a_done = 1'b0;
        chk("same_cycle_count", 64'(a_count), 64'd1);
        chk("same_cycle_loading", 64'(a_loading), 64'h0);
        fetch_a(32'h0, {1'b0, 32'hCAFEF00D});
        a_freq = 1'b0; cyc();

        // Small memory: overflow after 4 words.
        b_ls = 1'b1; cyc(); b_ls = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_lv = 1'b1; b_ld = 32'hB0000000 + 32'(i); cyc();
        end
        b_lv = 1'b0;
        chk("ovf_count", 64'(b_count), 64'd4);
        chk("ovf_flag", 64'(b_ovf), 64'h1);
        b_done = 1'b1; cyc(); b_done = 1'b0;
        chk("ovf_sticky", 64'(b_ovf), 64'h1);
        fetch_b(32'h0, {1'b0, 32'hB0000000});
        fetch_b(32'h4, {1'b0, 32'hB0000001});
        fetch_b(32'h8, {1'b0, 32'hB0000002});
        fetch_b(32'hC, {1'b0, 32'hB0000003});
        fetch_b(32'h10, {1'b1, 32'h00000000});
        b_freq = 1'b0; cyc();
        b_ls = 1'b1; cyc(); b_ls = 1'b0;
        chk("ovf_cleared", 64'(b_ovf), 64'h0);
        chk("reload_count", 64'(b_count), 64'h0);
        chk("reload_loading", 64'(b_loading), 64'h1);
        b_done = 1'b1; cyc(); b_done = 1'b0;

        cyc();
        cyc();
        chk("pending_a", 64'(exp_a.size()), 64'h0);
        chk("pending_b", 64'(exp_b.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS CPU.
- Replaces the hard-wired combinational instruction ROM with word-addressed RAM.
- A boot-load port streams the program in sequentially; the fetch port serves the PC with 1-cycle latency, stall hold, and address-fault detection.
- Sits between the PC/IF stage and the program-load source (UART loader or testbench).

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 32, byte-address width of the fetch Address port.
- DEPTH_LOG2, 8, log2 of the memory depth in words (default 256 words = 1 KiB).
- NOP_WORD, 32'h00000000, word returned for faulted, idle or loading fetches.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- LoadStart  in  1  enter LOAD state and clear the write pointer.
- LoadValid  in  1  LoadData is valid this cycle.
- LoadData  in  DATA_WIDTH  word to write at the write pointer.
- LoadDone  in  1  end of program; go to RUN.
- Loading  out  1  high while in LOAD.
- LoadCount  out  DEPTH_LOG2+1  number of words written in the current load.
- LoadOverflow  out  1  sticky flag: a write was attempted with the memory full.
- FetchReq  in  1  fetch request for Address.
- Stall  in  1  hold the fetch output registers.
- Address  in  ADDR_WIDTH  byte address (PC).
- Instruction  out  DATA_WIDTH  registered fetched word.
- InstrValid  out  1  Instruction is valid for the request of the previous cycle.
- AddrFault  out  1  registered with Instruction; the request was misaligned or out of range.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - state = IDLE; Loading = 0, LoadCount = 0, LoadOverflow = 0.
  - Instruction = NOP_WORD, InstrValid = 0, AddrFault = 0.
  - Memory contents are not cleared.
- States are IDLE, LOAD and RUN.
  - IDLE -> LOAD on LoadStart.
  - LOAD -> RUN on LoadDone.
  - RUN -> LOAD on LoadStart, which reloads the program.
  - IDLE -> RUN on LoadDone, which runs the existing contents.
  - LoadStart has priority over LoadDone when both are high in the same cycle.
- LOAD state:
  - On entry, the write pointer and LoadCount are 0.
  - Each LoadValid cycle writes mem[ptr] = LoadData, then ptr++ and LoadCount++.
  - If ptr == 2^DEPTH_LOG2, the write is dropped and LoadOverflow is set; it stays set until reset or the next LoadStart.
  - LoadValid and LoadDone in the same cycle: the word is written first, then the transition to RUN occurs.
  - LoadValid outside LOAD is ignored.
- Fetch is only serviced in RUN. Fetch index = Address[DEPTH_LOG2+1:2].
  - Fault condition: Address[1:0] != 0, or any bit of Address[ADDR_WIDTH-1:DEPTH_LOG2+2] is set.
- Fetch output update priority, evaluated each edge:
  1. Stall = 1: Instruction, InstrValid and AddrFault all hold, in any state.
  2. State != RUN: InstrValid = 0, Instruction = NOP_WORD, AddrFault = 0.
  3. FetchReq = 1, no fault: Instruction = mem[index], InstrValid = 1, AddrFault = 0. Latency is exactly 1 cycle.
  4. FetchReq = 1, fault: Instruction = NOP_WORD, InstrValid = 1, AddrFault = 1.
  5. FetchReq = 0: InstrValid = 0, AddrFault = 0, Instruction holds.
- Reads and writes never overlap, because writes occur only in LOAD; no read-during-write bypass is required.
- Reset mid-load returns to IDLE. Words already written are retained, and LoadCount reads 0.
- LoadCount saturates at 2^DEPTH_LOG2.

Test Plan:
- Load 18 words 0x20040003, 0x0C000003, …, then LoadDone; fetch 0x0, 0x4, 0x44 -> the next cycle returns 0x20040003, 0x0C000003 and word 17 respectively, InstrValid = 1, LoadCount = 18.
- In RUN, FetchReq with Address 0x8, then Stall held 3 cycles while Address changes -> Instruction stays mem[2] and InstrValid stays 1 for all 3 cycles.
- Fetch Address 0x6 and Address 0x400 (DEPTH_LOG2 = 8) -> Instruction = 0x00000000, InstrValid = 1, AddrFault = 1.
- DEPTH_LOG2 = 2: stream 6 LoadValid words -> LoadCount = 4, LoadOverflow = 1, words 5 and 6 are discarded; mem[0..3] are correct on fetch.
- Assert reset after 3 of 10 load words, then LoadDone -> state IDLE, then RUN; fetch 0x0..0x8 returns the 3 loaded words; LoadCount = 0.
- LoadValid + LoadDone in the same cycle as the 1st word -> the word is stored; the next-cycle fetch of 0x0 in RUN returns it.
